hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage RV32I core. Decodes the ID-stage
//  instruction's register use and detects load-use and branch-operand hazards.
//  Handles branch flush (beq resolved in ID) and multi-cycle data-memory waits.
//  Drives PC, IF/ID, ID/EX enables, plus one global hold for ID/EX, EX/MEM and MEM/WB.
// PARAMETERS
//  BRANCH_IN_ID  1    1: beq compares in ID, so it stalls on any EX/MEM producer of rs1/rs2
//  MAX_WAIT      64   MEM_WAIT cycles tolerated before err_o sets (>=1)
//  CNT_W         16   perf counter width (HAZ_PERF_CNT_EN only)
// PORTS
//  clk_i           in   1   clock, rising edge
//  rst_i           in   1   reset, asynchronous, active-high
//  start_i         in   1   level; sampled in IDLE only
//  id_instr_i      in   32  instruction in IF/ID register
//  ex_memread_i    in   1   EX-stage instr is a load
//  ex_regwrite_i   in   1   EX-stage instr writes rd
//  ex_rd_i         in   5   EX-stage rd
//  mem_memread_i   in   1   MEM-stage instr is a load
//  mem_rd_i        in   5   MEM-stage rd
//  branch_taken_i  in   1   ID-stage beq comparison result
//  mem_req_i       in   1   MEM stage accessing data memory
//  mem_ack_i       in   1   data memory done (same-cycle ack allowed)
//  pc_write_o      out  1   PC load enable
//  ifid_write_o    out  1   IF/ID load enable
//  ifid_flush_o    out  1   IF/ID clear to NOP
//  idex_nop_o      out  1   load bubble into ID/EX
//  pipe_hold_o     out  1   freeze ID/EX, EX/MEM, MEM/WB
//  state_o         out  2   00 IDLE, 01 RUN, 10 MEM_WAIT
//  err_o           out  1   sticky memory-timeout flag
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0, err_o 0, perf counters 0. Async, effective at any
//   time incl. mid MEM_WAIT; no pending stall or flush survives.
//  Decode: opc=instr[6:0], rs1=[19:15], rs2=[24:20]. uses_rs1 for opcodes 0010011,
//   0000011, 0100011, 1100011, 0110011; uses_rs2 for 0100011, 1100011, 0110011.
//   Any other opcode: no use, never stalls. A match is suppressed when rd==x0.
//  load_use = ex_memread_i & (rs1/rs2 used and equal ex_rd_i).
//  br_dep (BRANCH_IN_ID=1, opc 1100011 only) = (ex_regwrite_i & rs match ex_rd_i) |
//   (mem_memread_i & rs match mem_rd_i). Load then beq costs 2 stalls; ALU then beq costs 1.
//  Outputs are combinational from state and current inputs.
//  IDLE: pc_write/ifid_write 0, flush/nop 0, hold 1. start_i=1 -> RUN next edge.
//  RUN, priority high to low:
//   1 mem_req_i & !mem_ack_i: hold 1, pc/ifid write 0, nop 0, flush 0.
//     Next state MEM_WAIT, wait counter cleared to 1.
//   2 load_use | br_dep: pc/ifid write 0, idex_nop 1, hold 0. Re-checked each cycle.
//   3 opc 1100011 & branch_taken_i: pc/ifid write 1, ifid_flush 1.
//   4 else: pc/ifid write 1, others 0.
//  MEM_WAIT: hold 1, pc/ifid write 0, nop/flush 0, counter +1 per cycle.
//   mem_ack_i=1: this cycle outputs per RUN rules 2-4 with hold 0; next state RUN.
//   Hazards are evaluated against current ID/EX contents.
//   Counter reaching MAX_WAIT sets err_o; it stays waiting and does not abort.
//   The counter saturates.
//  start_i is ignored outside IDLE. The only exit from RUN or MEM_WAIT is reset.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds outputs stall_cnt_o[CNT_W] and flush_cnt_o[CNT_W].
//   stall_cnt_o counts cycles with pc_write_o=0 in RUN or MEM_WAIT.
//   flush_cnt_o counts ifid_flush_o cycles. Both saturate at all-ones, reset 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  rst_i=1 mid MEM_WAIT -> state_o 00, hold 1, pc_write 0, err_o 0 immediately, no clock.
//  RUN; EX lw x5 (memread=1, rd=5); ID add x6,x5,x1 -> one cycle pc_write 0, idex_nop 1,
//   then normal.
//  EX lw x5; ID beq x5,x0 -> two stall cycles (EX, then MEM match), then resolve.
//   branch_taken_i=1 -> ifid_flush 1.
//  mem_req=1, ack low 3 cycles -> MEM_WAIT 3 cycles with hold 1; ack cycle hold 0;
//   then RUN, err_o 0.
//  MAX_WAIT=4, ack never -> err_o rises on 4th wait cycle and stays 1; state stays 10.
//  EX rd=x0 with memread=1; ID add x0 use -> no stall. HAZ_PERF_CNT_EN build: counters
//   match the cycle counts above.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage RV32I core; detects load-use
// and branch-operand hazards, sequences IDLE/RUN/MEM_WAIT, and drives stage enables.
// Ports: clk_i/rst_i (async active-high), start_i, id_instr_i, EX/MEM hazard
// sideband, branch_taken_i, mem_req_i/mem_ack_i -> pc_write_o, ifid_write_o,
// ifid_flush_o, idex_nop_o, pipe_hold_o, state_o, err_o (sticky timeout).
// Optional macro HAZ_PERF_CNT_EN adds stall_cnt_o/flush_cnt_o perf counters.
module hazard_ctrl #(
  parameter int BRANCH_IN_ID = 1,
  parameter int MAX_WAIT     = 64,
  parameter int CNT_W        = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] id_instr_i,
  input  logic        ex_memread_i,
  input  logic        ex_regwrite_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        mem_memread_i,
  input  logic [4:0]  mem_rd_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_nop_o,
  output logic        pipe_hold_o,
  output logic [1:0]  state_o,
  output logic        err_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;

  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [6:0] opc;
  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2;
  logic       ex_match, mem_match;
  logic       load_use, br_dep, hazard, is_br;
  logic       adv_pc, adv_nop, adv_flush;
  logic       unused_bits;

  assign opc = id_instr_i[6:0];
  assign rs1 = id_instr_i[19:15];
  assign rs2 = id_instr_i[24:20];
  assign unused_bits = ^{id_instr_i[31:25], id_instr_i[14:7]};

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opc)
      OPC_IMM, OPC_LOAD: begin
        uses_rs1 = 1'b1;
      end
      OPC_STORE, OPC_BR, OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  // x0 is never a real producer, so a zero rd cannot create a dependency.
  assign ex_match = (ex_rd_i != 5'd0) &
                    ((uses_rs1 & (rs1 == ex_rd_i)) |
                     (uses_rs2 & (rs2 == ex_rd_i)));
  assign mem_match = (mem_rd_i != 5'd0) &
                     ((uses_rs1 & (rs1 == mem_rd_i)) |
                      (uses_rs2 & (rs2 == mem_rd_i)));

  assign is_br    = (opc == OPC_BR);
  assign load_use = ex_memread_i & ex_match;

  // beq compares in ID: any EX producer, or a load still in MEM, must retire
  // its value before the comparison is trustworthy.
  generate
    if (BRANCH_IN_ID != 0) begin : g_br_id
      assign br_dep = is_br &
                      ((ex_regwrite_i & ex_match) |
                       (mem_memread_i & mem_match));
    end else begin : g_br_ex
      logic unused_br;
      assign unused_br = ^{mem_match, mem_memread_i, ex_regwrite_i};
      assign br_dep    = 1'b0;
    end
  endgenerate

  assign hazard = load_use | br_dep;

  // Shared advance decision used by RUN and by the MEM_WAIT ack cycle.
  assign adv_pc    = ~hazard;
  assign adv_nop   = hazard;
  assign adv_flush = ~hazard & is_br & branch_taken_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_nop_o   = 1'b0;
    pipe_hold_o  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mem_req_i & ~mem_ack_i) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_ONE;
        end else begin
          pipe_hold_o  = 1'b0;
          pc_write_o   = adv_pc;
          ifid_write_o = adv_pc;
          idex_nop_o   = adv_nop;
          ifid_flush_o = adv_flush;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          state_d      = ST_RUN;
          pipe_hold_o  = 1'b0;
          pc_write_o   = adv_pc;
          ifid_write_o = adv_pc;
          idex_nop_o   = adv_nop;
          ifid_flush_o = adv_flush;
        end else if (cnt_q != WAIT_MAX) begin
          cnt_d = cnt_q + WAIT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Timeout only flags; the controller keeps waiting for the ack.
  assign err_d = err_q | ((state_d == ST_WAIT) & (cnt_d == WAIT_MAX));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state_o = state_q;
  assign err_o   = err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc;

  assign stall_inc = ((state_q == ST_RUN) | (state_q == ST_WAIT)) &
                     ~pc_write_o;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ifid_flush_o && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
